// File: rtl/ADC_DAQ_pkg.sv
// Shared constants and state encodings for the streaming DMA buffer scheduler.
// Coalesced interrupts are built when DMA_SCHED_COALESCE_EN is defined.
package ADC_DAQ_pkg;

    localparam int DMA_TLP_SIZE  = 128;
    localparam int DMA_NBUF_MAX  = 16;
    localparam int DMA_STRIDE_SH = $clog2(DMA_TLP_SIZE / 4);
    localparam int DMA_IDX_W     = $clog2(DMA_NBUF_MAX);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ARM  = 5'b00010,
        S_RUN  = 5'b00100,
        S_FULL = 5'b01000,
        S_STOP = 5'b10000
    } dma_state_t;

endpackage

// File: rtl/dma_buf_sched_addr_gen.sv
// Buffer start-address accumulator and ring index for the DMA scheduler.
// Addresses are DW units and wrap modulo 2^30.
module dma_buf_addr_gen
    import ADC_DAQ_pkg::*;
#(
    parameter int NBUF = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_adv,
    input  logic [31:2]          i_base,
    input  logic [31:7]          i_size,
    output logic [31:2]          o_addr,
    output logic [DMA_IDX_W-1:0] o_idx
);

    localparam logic [DMA_IDX_W-1:0] LAST = DMA_IDX_W'(NBUF - 1);

    logic [31:2]          r_addr;
    logic [DMA_IDX_W-1:0] r_idx;
    logic [31:2]          w_stride;

    assign w_stride = {i_size, {DMA_STRIDE_SH{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
            r_idx  <= '0;
        end else if (i_adv) begin
            if (r_idx == LAST) begin
                r_addr <= i_base;
                r_idx  <= '0;
            end else begin
                r_addr <= r_addr + w_stride;
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_idx  = r_idx;

endmodule

// File: rtl/dma_buf_sched.sv
// Host-buffer ring scheduler: gates engine ready against ring occupancy.
// Define DMA_SCHED_COALESCE_EN for coalesced host interrupts.
module dma_buf_sched
    import ADC_DAQ_pkg::*;
#(
    parameter int NBUF = 8
) (
    input  logic        trn_clk,
    input  logic        pio_reset_n,
    input  logic        stream_on,
    input  logic [31:2] buf_base,
    input  logic [31:7] dma_size,
    input  logic [3:0]  coal_n,
    input  logic        host_rel,
    input  logic        fifo_ready,
    input  logic        fifo_full,
    input  logic        eng_irq,
    input  logic        eng_busy,
    output logic        eng_stream_on,
    output logic        eng_dma_ready,
    output logic [31:2] eng_init_addr,
    output logic        irq_o,
    output logic [3:0]  wr_idx,
    output logic [4:0]  occ,
    output logic        overflow_o,
    output logic        rel_err_o
);

    localparam logic [4:0] NB = 5'(NBUF);

    dma_state_t r_state;
    dma_state_t w_nxt;
    logic       r_arm_cnt;
    logic       r_rdy;
    logic       r_irq;
    logic [4:0] r_occ;
    logic       r_ovf;
    logic       r_rel_err;
    logic       w_load;
    logic       w_adv;
    logic       w_live;
    logic       w_rdy_d;
    logic       w_stop_in;

    always_ff @(posedge trn_clk or negedge pio_reset_n) begin
        if (!pio_reset_n) r_state <= S_IDLE;
        else              r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (stream_on) w_nxt = S_ARM;
            S_ARM: begin
                if (!stream_on)     w_nxt = S_STOP;
                else if (r_arm_cnt) w_nxt = (r_occ == NB) ? S_FULL : S_RUN;
            end
            S_RUN: begin
                if (!stream_on)   w_nxt = S_STOP;
                else if (eng_irq) w_nxt = S_ARM;
            end
            S_FULL: begin
                if (!stream_on)    w_nxt = S_STOP;
                else if (host_rel) w_nxt = S_ARM;
            end
            S_STOP: if (!eng_busy) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load    = (r_state == S_IDLE) && stream_on;
        w_adv     = (r_state == S_RUN) && eng_irq;
        w_live    = (r_state != S_IDLE);
        w_rdy_d   = (w_nxt == S_RUN) && fifo_ready;
        w_stop_in = (w_nxt == S_STOP) && (r_state != S_STOP);
    end

    // ARM holds for exactly two cycles so the engine reloads while idle
    always_ff @(posedge trn_clk or negedge pio_reset_n) begin
        if (!pio_reset_n) begin
            r_arm_cnt <= 1'b0;
            r_rdy     <= 1'b0;
        end else begin
            r_arm_cnt <= (r_state == S_ARM) ? ~r_arm_cnt : 1'b0;
            r_rdy     <= w_rdy_d;
        end
    end

    always_ff @(posedge trn_clk or negedge pio_reset_n) begin
        if (!pio_reset_n) begin
            r_occ     <= '0;
            r_ovf     <= 1'b0;
            r_rel_err <= 1'b0;
        end else if (w_load) begin
            r_occ     <= '0;
            r_ovf     <= 1'b0;
            r_rel_err <= 1'b0;
        end else if (w_live) begin
            if (eng_irq && !host_rel && r_occ != NB) begin
                r_occ <= r_occ + 1'b1;
            end else if (host_rel && !eng_irq) begin
                if (r_occ == '0) r_rel_err <= 1'b1;
                else             r_occ     <= r_occ - 1'b1;
            end
            if (r_state == S_FULL && fifo_full) r_ovf <= 1'b1;
        end
    end

`ifdef DMA_SCHED_COALESCE_EN
    logic [3:0] r_pend;
    logic [4:0] w_thr;
    logic       w_hit;

    assign w_thr = (coal_n == '0) ? 5'd1 : {1'b0, coal_n};
    assign w_hit = eng_irq && ({1'b0, r_pend} + 5'd1 >= w_thr);

    always_ff @(posedge trn_clk or negedge pio_reset_n) begin
        if (!pio_reset_n) begin
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else if (w_load) begin
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else if (!w_live) begin
            r_irq <= 1'b0;
        end else if (w_stop_in) begin
            r_irq  <= w_hit || eng_irq || (r_pend != '0);
            r_pend <= '0;
        end else if (w_hit) begin
            r_irq  <= 1'b1;
            r_pend <= '0;
        end else begin
            r_irq  <= 1'b0;
            r_pend <= r_pend + {3'b0, eng_irq};
        end
    end
`else
    logic w_unused_coal;
    assign w_unused_coal = ^{coal_n, w_stop_in};

    always_ff @(posedge trn_clk or negedge pio_reset_n) begin
        if (!pio_reset_n) r_irq <= 1'b0;
        else              r_irq <= eng_irq && w_live;
    end
`endif

    dma_buf_addr_gen #(
        .NBUF (NBUF)
    ) u_addr (
        .clk    (trn_clk),
        .rst_n  (pio_reset_n),
        .i_load (w_load),
        .i_adv  (w_adv),
        .i_base (buf_base),
        .i_size (dma_size),
        .o_addr (eng_init_addr),
        .o_idx  (wr_idx)
    );

    assign eng_stream_on = (r_state != S_IDLE);
    assign eng_dma_ready = r_rdy;
    assign irq_o         = r_irq;
    assign occ           = r_occ;
    assign overflow_o    = r_ovf;
    assign rel_err_o     = r_rel_err;

endmodule

// File: tb/tb_dma_buf_sched.sv
// Directed bench for dma_buf_sched with a four-buffer ring.
// Coalescing expectations follow DMA_SCHED_COALESCE_EN.
module tb_dma_buf_sched;

    localparam int NBUF = 4;

    logic        trn_clk = 1'b0;
    logic        pio_reset_n;
    logic        stream_on;
    logic [31:2] buf_base;
    logic [31:7] dma_size;
    logic [3:0]  coal_n;
    logic        host_rel;
    logic        fifo_ready;
    logic        fifo_full;
    logic        eng_irq;
    logic        eng_busy;
    logic        eng_stream_on;
    logic        eng_dma_ready;
    logic [31:2] eng_init_addr;
    logic        irq_o;
    logic [3:0]  wr_idx;
    logic [4:0]  occ;
    logic        overflow_o;
    logic        rel_err_o;

    int n_tot = 0;
    int n_bad = 0;

    always #5 trn_clk = ~trn_clk;

    dma_buf_sched #(.NBUF(NBUF)) dut (
        .trn_clk       (trn_clk),
        .pio_reset_n   (pio_reset_n),
        .stream_on     (stream_on),
        .buf_base      (buf_base),
        .dma_size      (dma_size),
        .coal_n        (coal_n),
        .host_rel      (host_rel),
        .fifo_ready    (fifo_ready),
        .fifo_full     (fifo_full),
        .eng_irq       (eng_irq),
        .eng_busy      (eng_busy),
        .eng_stream_on (eng_stream_on),
        .eng_dma_ready (eng_dma_ready),
        .eng_init_addr (eng_init_addr),
        .irq_o         (irq_o),
        .wr_idx        (wr_idx),
        .occ           (occ),
        .overflow_o    (overflow_o),
        .rel_err_o     (rel_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic irq_pulse();
        eng_irq = 1'b1;
        step();
        eng_irq = 1'b0;
    endtask

    task automatic rel_pulse();
        host_rel = 1'b1;
        step();
        host_rel = 1'b0;
    endtask

    logic [31:0] exp_addr [4] = '{32'h1040, 32'h1080, 32'h10C0, 32'h1000};
    logic [31:0] exp_irq;

    initial begin
        pio_reset_n = 1'b0;
        stream_on   = 1'b0;
        buf_base    = 30'h1000;
        dma_size    = 25'd2;
        coal_n      = 4'd3;
        host_rel    = 1'b0;
        fifo_ready  = 1'b1;
        fifo_full   = 1'b0;
        eng_irq     = 1'b0;
        eng_busy    = 1'b0;
        step();
        step();
        chk("rst_son", 32'(eng_stream_on), 0);
        chk("rst_rdy", 32'(eng_dma_ready), 0);
        chk("rst_addr", 32'(eng_init_addr), 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_idx", 32'(wr_idx), 0);
        chk("rst_irq", 32'(irq_o), 0);

        // start
        pio_reset_n = 1'b1;
        stream_on   = 1'b1;
        step();
        chk("st_son", 32'(eng_stream_on), 1);
        chk("st_arm0_rdy", 32'(eng_dma_ready), 0);
        chk("st_addr", 32'(eng_init_addr), 32'h1000);
        step();
        chk("st_arm1_rdy", 32'(eng_dma_ready), 0);
        step();
        chk("st_run_rdy", 32'(eng_dma_ready), 1);

        // wrap with a release after every buffer
        for (int k = 0; k < 4; k++) begin
            irq_pulse();
            chk("wr_rdy0", 32'(eng_dma_ready), 0);
            chk("wr_addr", 32'(eng_init_addr), exp_addr[k]);
            chk("wr_idx", 32'(wr_idx), 32'((k + 1) % 4));
            chk("wr_irq", 32'(irq_o), 1);
            chk("wr_occ", 32'(occ), 1);
            rel_pulse();
            chk("wr_occ_rel", 32'(occ), 0);
            chk("wr_rdy1", 32'(eng_dma_ready), 0);
            step();
            chk("wr_rdy3", 32'(eng_dma_ready), 1);
        end

        // fill the ring
        for (int k = 0; k < 4; k++) begin
            irq_pulse();
            step();
            step();
        end
        chk("fu_occ", 32'(occ), 4);
        chk("fu_rdy", 32'(eng_dma_ready), 0);
        chk("fu_ovf0", 32'(overflow_o), 0);
        step();
        chk("fu_rdy_hold", 32'(eng_dma_ready), 0);
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        chk("fu_ovf1", 32'(overflow_o), 1);
        rel_pulse();
        chk("fu_occ_rel", 32'(occ), 3);
        chk("fu_arm_rdy", 32'(eng_dma_ready), 0);
        step();
        step();
        chk("fu_run_rdy", 32'(eng_dma_ready), 1);

        // simultaneous completion and release, then underflow
        rel_pulse();
        chk("si_occ2", 32'(occ), 2);
        eng_irq  = 1'b1;
        host_rel = 1'b1;
        step();
        eng_irq  = 1'b0;
        host_rel = 1'b0;
        chk("si_occ_same", 32'(occ), 2);
        step();
        step();
        rel_pulse();
        rel_pulse();
        chk("un_occ0", 32'(occ), 0);
        chk("un_err0", 32'(rel_err_o), 0);
        rel_pulse();
        chk("un_err1", 32'(rel_err_o), 1);
        chk("un_occ", 32'(occ), 0);
        chk("un_ovf_sticky", 32'(overflow_o), 1);

        // stop while the engine is mid-TLP
        eng_busy  = 1'b1;
        stream_on = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("sp_son_busy", 32'(eng_stream_on), 1);
            chk("sp_rdy", 32'(eng_dma_ready), 0);
        end
        eng_busy = 1'b0;
        step();
        chk("sp_son_off", 32'(eng_stream_on), 0);
        chk("sp_keep_err", 32'(rel_err_o), 1);
        chk("sp_keep_idx", 32'(wr_idx), 1);
        step();
        chk("sp_idle", 32'(eng_stream_on), 0);

        // restart clears counters and stickies
        stream_on = 1'b1;
        step();
        chk("rs_son", 32'(eng_stream_on), 1);
        chk("rs_err", 32'(rel_err_o), 0);
        chk("rs_ovf", 32'(overflow_o), 0);
        chk("rs_idx", 32'(wr_idx), 0);
        chk("rs_addr", 32'(eng_init_addr), 32'h1000);
        step();
        step();

        // interrupt pacing
        for (int k = 1; k <= 7; k++) begin
`ifdef DMA_SCHED_COALESCE_EN
            exp_irq = (k % 3 == 0) ? 32'd1 : 32'd0;
`else
            exp_irq = 32'd1;
`endif
            irq_pulse();
            chk("co_irq", 32'(irq_o), exp_irq);
            rel_pulse();
            chk("co_irq_off", 32'(irq_o), 0);
            step();
        end
        stream_on = 1'b0;
        step();
`ifdef DMA_SCHED_COALESCE_EN
        exp_irq = 32'd1;
`else
        exp_irq = 32'd0;
`endif
        chk("co_flush", 32'(irq_o), exp_irq);
        step();
        chk("co_idle", 32'(eng_stream_on), 0);
        chk("co_idle_irq", 32'(irq_o), 0);

        // asynchronous reset mid-stream
        stream_on = 1'b1;
        step();
        step();
        #2 pio_reset_n = 1'b0;
        #1;
        chk("ar_son", 32'(eng_stream_on), 0);
        chk("ar_addr", 32'(eng_init_addr), 0);
        chk("ar_rdy", 32'(eng_dma_ready), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
